// File: rtl/sample_echo_memory_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sample_echo_memory_scheduler
//  Description : Schedules a single-port delay RAM for a stereo echo. Each
//                accepted sample is paired with the same-channel sample
//                written D = 2*delay_samples entries earlier. L/R samples
//                are interleaved, and left samples live at even addresses.
//                The RAM is zeroed after reset and on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_echo_memory_scheduler #(
  parameter int audio_width   = 16,
  parameter int delay_samples = 1024,
  parameter int addr_width    = $clog2(2 * delay_samples)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_is_left,
  input  logic [audio_width-1:0] i_audio,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   o_is_left,
  output logic [audio_width-1:0] o_audio,
  output logic [audio_width-1:0] o_delayed_audio,
  output logic [addr_width-1:0]  mem_addr,
  output logic                   mem_we,
  output logic [audio_width-1:0] mem_wdata,
  input  logic [audio_width-1:0] mem_rdata,
  output logic                   busy,
  output logic                   resync
);

  localparam int                    c_depth = 2 * delay_samples;
  localparam logic [addr_width-1:0] c_last  = addr_width'(c_depth - 1);
  localparam logic [addr_width-1:0] c_one   = addr_width'(1);

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t                 state_q,   state_d;
  logic [addr_width-1:0]  clr_cnt_q, clr_cnt_d;
  logic [addr_width-1:0]  ptr_q,     ptr_d;
  // Low only while reset is held: keeps the RAM write strobe quiet during
  // reset even though the state already reads CLEAR.
  logic                   armed_q,   armed_d;
  logic [audio_width-1:0] sample_q,  sample_d;
  logic                   is_left_q, is_left_d;
  logic [audio_width-1:0] delayed_q, delayed_d;
  logic                   resync_q,  resync_d;

  // Modulo-D increment; D need not be a power of two, so compare explicitly.
  function automatic logic [addr_width-1:0] wrap_inc(input logic [addr_width-1:0] v);
    return (v == c_last) ? '0 : v + c_one;
  endfunction

  // State register and datapath flops, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ptr_q     <= '0;
      armed_q   <= 1'b0;
      sample_q  <= '0;
      is_left_q <= 1'b0;
      delayed_q <= '0;
      resync_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
      armed_q   <= armed_d;
      sample_q  <= sample_d;
      is_left_q <= is_left_d;
      delayed_q <= delayed_d;
      resync_q  <= resync_d;
    end
  end

  // Next-state logic and RAM/handshake outputs.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ptr_d     = ptr_q;
    armed_d   = 1'b1;
    sample_d  = sample_q;
    is_left_d = is_left_q;
    delayed_d = delayed_q;
    resync_d  = 1'b0;
    i_ready   = 1'b0;
    o_valid   = 1'b0;
    mem_addr  = ptr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        busy     = 1'b1;
        mem_addr = clr_cnt_q;
        mem_we   = armed_q;
        if (armed_q) begin
          if (clr_cnt_q == c_last) begin
            state_d   = ST_IDLE;
            clr_cnt_d = '0;
            ptr_d     = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + c_one;
          end
        end
      end
      ST_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          sample_d  = i_audio;
          is_left_d = i_is_left;
          // A left sample must land on an even slot; skip one slot if not.
          if (i_is_left != ~ptr_q[0]) begin
            ptr_d    = wrap_inc(ptr_q);
            resync_d = 1'b1;
          end
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = sample_q;
        delayed_d = mem_rdata;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        o_valid = 1'b1;
        if (o_ready) begin
          ptr_d   = wrap_inc(ptr_q);
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    // A clear request overrides everything and restarts the zeroing pass.
    if (clear) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
      ptr_d     = '0;
      resync_d  = 1'b0;
    end
  end

  assign o_is_left       = is_left_q;
  assign o_audio         = sample_q;
  assign o_delayed_audio = delayed_q;
  assign resync          = resync_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_echo_memory_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_echo_memory_scheduler
//  Description : Self-checking bench for sample_echo_memory_scheduler with a
//                behavioural RAM and a frame-level echo reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_echo_memory_scheduler;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_is_left = 1'b0;
  logic [15:0] i_audio = '0;
  logic        o_ready = 1'b1;
  logic        i_ready, o_valid, o_is_left, mem_we, busy, resync;
  logic [15:0] o_audio, o_delayed_audio, mem_wdata;
  logic [15:0] mem_rdata;
  logic [2:0]  mem_addr;

  logic [15:0] ram [D];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: contents of the echo memory and the write slot.
  logic [15:0] mdl_mem [D];
  int          mdl_ptr;

  sample_echo_memory_scheduler #(
    .audio_width  (16),
    .delay_samples(4),
    .addr_width   (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .i_valid        (i_valid),
    .i_ready        (i_ready),
    .i_is_left      (i_is_left),
    .i_audio        (i_audio),
    .o_valid        (o_valid),
    .o_ready        (o_ready),
    .o_is_left      (o_is_left),
    .o_audio        (o_audio),
    .o_delayed_audio(o_delayed_audio),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .resync         (resync)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < D; i++) mdl_mem[i] = '0;
    mdl_ptr = 0;
  endtask

  // Echo rule: left goes to an even slot, output pairs with the slot's old content.
  task automatic model_step(input bit left, input logic [15:0] data,
                            output logic [2:0] e_addr, output logic [15:0] e_del,
                            output int e_rs);
    e_rs = (left != ((mdl_ptr % 2) == 0)) ? 1 : 0;
    if (e_rs == 1) mdl_ptr = (mdl_ptr + 1) % D;
    e_addr = 3'(mdl_ptr);
    e_del  = mdl_mem[mdl_ptr];
    mdl_mem[mdl_ptr] = data;
    mdl_ptr = (mdl_ptr + 1) % D;
  endtask

  // Observe D cycles of the clearing pass starting at the current cycle.
  task automatic watch_clear(output int nwr, output int nbusy);
    nwr = 0;
    nbusy = 0;
    for (int i = 0; i < D; i++) begin
      if (mem_we === 1'b1 && mem_addr === 3'(i) && mem_wdata === 16'h0) nwr++;
      if (busy === 1'b1) nbusy++;
      tick();
    end
  endtask

  // Drive one sample through the block and report what was observed.
  task automatic xfer(input bit left, input logic [15:0] data, input int hold,
                      output int lat, output int n_rs, output int n_wr,
                      output logic [2:0] wr_addr, output logic [15:0] wr_data,
                      output logic [15:0] out_a, output logic out_l,
                      output logic [15:0] out_d, output bit hold_ok,
                      output bit done_ok);
    int w;
    lat = 0; n_rs = 0; n_wr = 0; wr_addr = 'x; wr_data = 'x;
    hold_ok = 1'b1; done_ok = 1'b0;
    o_ready = (hold == 0);
    w = 0;
    while (i_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    i_valid = 1'b1; i_is_left = left; i_audio = data;
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 10) begin
      if (resync === 1'b1) n_rs++;
      if (mem_we === 1'b1) begin
        n_wr++;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end
      tick();
      lat++;
    end
    out_a = o_audio; out_l = o_is_left; out_d = o_delayed_audio;
    for (int h = 0; h < hold - 1; h++) begin
      tick();
      if (o_valid !== 1'b1 || o_audio !== out_a || o_is_left !== out_l ||
          o_delayed_audio !== out_d || i_ready !== 1'b0 || mem_we !== 1'b0 ||
          resync !== 1'b0) hold_ok = 1'b0;
    end
    o_ready = 1'b1;
    if (o_valid === 1'b1) begin
      tick();
      done_ok = (o_valid === 1'b0) && (i_ready === 1'b1);
    end
  endtask

  task automatic test_reset;
    int nwr, nb;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({i_ready, o_valid, busy, mem_we, resync, o_is_left} !== 6'b001000 ||
        mem_addr !== 3'd0 || mem_wdata !== 16'h0 || o_audio !== 16'h0 ||
        o_delayed_audio !== 16'h0) begin
      n_err++;
      $display("FAIL reset_values: got rdy/vld/busy/we/rs/left=%b addr=%0d wdata=%h oa=%h od=%h, expected 001000 0 0000 0000 0000",
               {i_ready, o_valid, busy, mem_we, resync, o_is_left}, mem_addr, mem_wdata, o_audio, o_delayed_audio);
    end
    reset = 1'b1;
    tick();
    watch_clear(nwr, nb);
    n_vec++;
    if (nwr != D) begin n_err++; $display("FAIL reset_clear_writes: got %0d expected %0d", nwr, D); end
    n_vec++;
    if (nb != D) begin n_err++; $display("FAIL reset_busy_cycles: got %0d expected %0d", nb, D); end
    n_vec++;
    if (i_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_cycle9: got rdy=%b busy=%b expected rdy=1 busy=0", i_ready, busy);
    end
    model_clear();
  endtask

  task automatic test_basic;
    int lat, nrs, nwr, ers;
    logic [2:0] wa, ea;
    logic [15:0] wd, oa, od, ed;
    logic ol;
    bit hok, dok;
    for (int k = 0; k < 2; k++) begin
      logic [15:0] d;
      d = (k == 0) ? 16'h1111 : 16'h2222;
      model_step(k == 0, d, ea, ed, ers);
      xfer(k == 0, d, 0, lat, nrs, nwr, wa, wd, oa, ol, od, hok, dok);
      n_vec++;
      if (lat != 3) begin n_err++; $display("FAIL basic_latency[%0d]: got %0d expected 3", k, lat); end
      n_vec++;
      if (od !== 16'h0000) begin n_err++; $display("FAIL basic_delayed[%0d]: got %h expected 0000", k, od); end
      n_vec++;
      if (wa !== 3'(k) || wd !== d || nwr != 1) begin
        n_err++;
        $display("FAIL basic_write[%0d]: got addr=%0d data=%h n=%0d expected addr=%0d data=%h n=1", k, wa, wd, nwr, k, d);
      end
      n_vec++;
      if (oa !== d || ol !== (k == 0) || !dok) begin
        n_err++;
        $display("FAIL basic_output[%0d]: got a=%h l=%b done=%b expected a=%h l=%b done=1", k, oa, ol, dok, d, k == 0);
      end
    end
  endtask

  task automatic test_wrap;
    int lat, nrs, nwr, ers, nclr, nb;
    logic [2:0] wa, ea;
    logic [15:0] wd, oa, od, ed, d;
    logic ol;
    bit hok, dok, left;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    watch_clear(nclr, nb);
    n_vec++;
    if (nclr != D || i_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clear_pass: got writes=%0d rdy=%b expected writes=%0d rdy=1", nclr, i_ready, D);
    end
    model_clear();
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 2; c++) begin
        left = (c == 0);
        d = left ? 16'h0100 + 16'(n) : 16'h0200 + 16'(n);
        model_step(left, d, ea, ed, ers);
        xfer(left, d, 0, lat, nrs, nwr, wa, wd, oa, ol, od, hok, dok);
        n_vec++;
        if (wa !== ea || od !== ed || nrs != 0) begin
          n_err++;
          $display("FAIL wrap_frame[%0d.%0d]: got addr=%0d del=%h rs=%0d expected addr=%0d del=%h rs=0", n, c, wa, od, nrs, ea, ed);
        end
        if (n == 4) begin
          n_vec++;
          if (od !== (left ? 16'h0100 : 16'h0200)) begin
            n_err++;
            $display("FAIL wrap_echo[%0d]: got %h expected %h", c, od, left ? 16'h0100 : 16'h0200);
          end
        end
      end
    end
  endtask

  task automatic test_resync;
    int lat, nrs, nwr, ers, tot_rs, tot_ers;
    logic [2:0] wa, ea;
    logic [15:0] wd, oa, od, ed, d;
    logic ol;
    bit hok, dok;
    tot_rs = 0; tot_ers = 0;
    for (int k = 0; k < 2; k++) begin
      d = 16'($urandom);
      model_step(1'b1, d, ea, ed, ers);
      xfer(1'b1, d, 0, lat, nrs, nwr, wa, wd, oa, ol, od, hok, dok);
      tot_rs += nrs;
      tot_ers += ers;
      n_vec++;
      if (wa !== ea || wa[0] !== 1'b0 || od !== ed) begin
        n_err++;
        $display("FAIL resync_left[%0d]: got addr=%0d del=%h expected addr=%0d del=%h", k, wa, od, ea, ed);
      end
    end
    n_vec++;
    if (tot_rs != 1 || tot_ers != 1) begin
      n_err++;
      $display("FAIL resync_pulses: got %0d expected 1", tot_rs);
    end
  endtask

  task automatic test_backpressure;
    int lat, nrs, nwr, ers;
    logic [2:0] wa, ea;
    logic [15:0] wd, oa, od, ed, d;
    logic ol;
    bit hok, dok, left;
    left = (mdl_ptr % 2) == 0;
    d = 16'($urandom);
    model_step(left, d, ea, ed, ers);
    xfer(left, d, 10, lat, nrs, nwr, wa, wd, oa, ol, od, hok, dok);
    n_vec++;
    if (!hok) begin n_err++; $display("FAIL bp_hold_stable: got unstable expected stable"); end
    n_vec++;
    if (!dok) begin n_err++; $display("FAIL bp_release: got no handshake expected one-cycle handshake"); end
    n_vec++;
    if (oa !== d || od !== ed || wa !== ea) begin
      n_err++;
      $display("FAIL bp_data: got a=%h del=%h addr=%0d expected a=%h del=%h addr=%0d", oa, od, wa, d, ed, ea);
    end
  endtask

  task automatic test_random;
    int lat, nrs, nwr, ers, hold;
    logic [2:0] wa, ea;
    logic [15:0] wd, oa, od, ed, d;
    logic ol;
    bit hok, dok, left;
    for (int k = 0; k < 40; k++) begin
      left = ((mdl_ptr % 2) == 0);
      if ($urandom_range(0, 5) == 0) left = ~left;
      d = 16'($urandom);
      hold = int'($urandom_range(0, 3));
      model_step(left, d, ea, ed, ers);
      xfer(left, d, hold, lat, nrs, nwr, wa, wd, oa, ol, od, hok, dok);
      n_vec++;
      if (lat != 3 || !dok || !hok) begin
        n_err++;
        $display("FAIL rnd_timing[%0d]: got lat=%0d done=%b hold=%b expected lat=3 done=1 hold=1", k, lat, dok, hok);
      end
      n_vec++;
      if (od !== ed || oa !== d || ol !== left) begin
        n_err++;
        $display("FAIL rnd_output[%0d]: got a=%h l=%b del=%h expected a=%h l=%b del=%h", k, oa, ol, od, d, left, ed);
      end
      n_vec++;
      if (wa !== ea || wd !== d || nwr != 1 || nrs != ers) begin
        n_err++;
        $display("FAIL rnd_write[%0d]: got addr=%0d data=%h n=%0d rs=%0d expected addr=%0d data=%h n=1 rs=%0d", k, wa, wd, nwr, nrs, ea, d, ers);
      end
    end
  endtask

  task automatic test_clear_reset;
    int lat, nrs, nwr, ers, nclr, nb, w;
    logic [2:0] wa, ea;
    logic [15:0] wd, oa, od, ed, d;
    logic ol;
    bit hok, dok;
    w = 0;
    while (i_ready !== 1'b1 && w < 20) begin tick(); w++; end
    i_valid = 1'b1; i_is_left = 1'b1; i_audio = 16'hBEEF;
    tick();
    i_valid = 1'b0;
    tick();
    n_vec++;
    if (mem_we !== 1'b1) begin n_err++; $display("FAIL cr_in_write: got we=%b expected 1", mem_we); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_vec++;
    if (o_valid !== 1'b0 || busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 3'd0) begin
      n_err++;
      $display("FAIL cr_clear_entry: got vld=%b busy=%b we=%b addr=%0d expected 0 1 1 0", o_valid, busy, mem_we, mem_addr);
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if ({i_ready, o_valid, busy, mem_we, resync, o_is_left} !== 6'b001000 ||
        mem_addr !== 3'd0 || mem_wdata !== 16'h0 || o_audio !== 16'h0 ||
        o_delayed_audio !== 16'h0) begin
      n_err++;
      $display("FAIL cr_async_reset: got rdy/vld/busy/we/rs/left=%b addr=%0d wdata=%h oa=%h od=%h expected 001000 0 0000 0000 0000",
               {i_ready, o_valid, busy, mem_we, resync, o_is_left}, mem_addr, mem_wdata, o_audio, o_delayed_audio);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    watch_clear(nclr, nb);
    n_vec++;
    if (nclr != D || nb != D || i_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cr_restart_clear: got writes=%0d busy=%0d rdy=%b expected %0d %0d 1", nclr, nb, i_ready, D, D);
    end
    model_clear();
    d = 16'($urandom);
    model_step(1'b1, d, ea, ed, ers);
    xfer(1'b1, d, 0, lat, nrs, nwr, wa, wd, oa, ol, od, hok, dok);
    n_vec++;
    if (wa !== 3'd0 || od !== 16'h0000 || lat != 3) begin
      n_err++;
      $display("FAIL cr_first_after: got addr=%0d del=%h lat=%0d expected 0 0000 3", wa, od, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_resync();
    test_backpressure();
    test_random();
    test_clear_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
